// File: rtl/reg_writeback_ctrl.sv
// Register-file write-side controller: merges ALU (port A) and long-latency (port B, FIFO-buffered)
// results into one registered write stream, and tracks in-flight destinations for decode stalls.
module reg_writeback_ctrl #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_dest,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_dest,
  input  logic [XLEN-1:0] b_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_dest,
  output logic            issue_ready,
  input  logic [4:0]      q_src1,
  input  logic [4:0]      q_src2,
  output logic            stall,
  output logic            wb_reg_write,
  output logic [4:0]      wb_dest,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [4:0]      r_mem_dest [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [31:0]     r_pend;
  logic            r_we;
  logic [4:0]      r_dest;
  logic [XLEN-1:0] r_data;
  logic            r_err;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_head_dest;
  logic [XLEN-1:0] w_head_data;
  logic            w_set;
  logic            w_hit1;
  logic            w_hit2;
  logic [31:0]     w_pend_nxt;
  logic            w_err_nxt;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push      = b_valid && !w_full;
  assign w_pop       = !a_valid && !w_empty;
  assign w_head_dest = r_mem_dest[r_rptr[AW-1:0]];
  assign w_head_data = r_mem_data[r_rptr[AW-1:0]];

  assign b_ready     = !w_full;
  assign issue_ready = !r_pend[issue_dest] || (issue_dest == '0);
  assign w_set       = issue_valid && issue_ready && (issue_dest != '0);

  // Covers the window between output-register load and the actual register-file write.
  assign w_hit1 = (q_src1 != '0) && (r_pend[q_src1] || (r_we && (r_dest == q_src1)) ||
                                     (a_valid && (a_dest == q_src1)));
  assign w_hit2 = (q_src2 != '0) && (r_pend[q_src2] || (r_we && (r_dest == q_src2)) ||
                                     (a_valid && (a_dest == q_src2)));
  assign stall  = w_hit1 || w_hit2;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop && (w_head_dest != '0)) w_pend_nxt[w_head_dest] = 1'b0;
    if (w_set) w_pend_nxt[issue_dest] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_err_nxt = r_err;
    if (a_valid && (a_dest != '0) && r_pend[a_dest]) w_err_nxt = 1'b1;
    if (w_pop && (w_head_dest != '0) && !r_pend[w_head_dest]) w_err_nxt = 1'b1;
    if (issue_valid && !issue_ready) w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dest[r_wptr[AW-1:0]] <= b_dest;
      r_mem_data[r_wptr[AW-1:0]] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_pend <= '0;
      r_we   <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      r_pend <= w_pend_nxt;
      r_err  <= w_err_nxt;
      if (a_valid) begin
        r_we   <= (a_dest != '0);
        r_dest <= a_dest;
        r_data <= a_data;
      end else if (w_pop) begin
        r_we   <= (w_head_dest != '0);
        r_dest <= w_head_dest;
        r_data <= w_head_data;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign wb_reg_write = r_we;
  assign wb_dest      = r_dest;
  assign wb_data      = r_data;
  assign err          = r_err;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_reg_writeback_ctrl;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_dest;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_dest;
  logic [31:0] b_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic [4:0]  q_src1;
  logic [4:0]  q_src2;
  logic        stall;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        err;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .q_src1(q_src1), .q_src2(q_src2), .stall(stall),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: FIFO as a queue, scoreboard as a bit array.
  typedef struct packed { logic [4:0] d; logic [31:0] v; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpend;
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic        m_err;
  bit          m_known = 0;

  function automatic logic m_hit(input logic [4:0] s);
    return (s != 0) && (mpend[s] || (m_we && m_dest == s) || (a_valid && a_dest == s));
  endfunction

  task automatic model_edge();
    logic        bready, iready, err_n;
    logic [31:0] np;
    ent_t        e;
    if (!rst) begin
      mq.delete();
      mpend = 0; m_we = 0; m_dest = 0; m_data = 0; m_err = 0; m_known = 1;
      return;
    end
    bready = (mq.size() < DEPTH);
    iready = (issue_dest == 0) || !mpend[issue_dest];
    np     = mpend;
    err_n  = m_err;
    if (issue_valid && !iready) err_n = 1;
    if (a_valid) begin
      if (a_dest != 0 && mpend[a_dest]) err_n = 1;
      m_we = (a_dest != 0); m_dest = a_dest; m_data = a_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.d != 0) begin
        if (!mpend[e.d]) err_n = 1;
        np[e.d] = 0;
      end
      m_we = (e.d != 0); m_dest = e.d; m_data = e.v;
    end else begin
      m_we = 0;
    end
    if (issue_valid && iready && issue_dest != 0) np[issue_dest] = 1;
    if (b_valid && bready) mq.push_back('{d: b_dest, v: b_data});
    mpend = np;
    m_err = err_n;
  endtask

  // One clock: combinational checks before the edge, registered checks 1 time unit after it.
  task automatic step();
    #1;
    if (m_known) begin
      chk("b_ready", 32'(b_ready), 32'(mq.size() < DEPTH));
      chk("issue_ready", 32'(issue_ready), 32'((issue_dest == 0) || !mpend[issue_dest]));
      chk("stall", 32'(stall), 32'(m_hit(q_src1) || m_hit(q_src2)));
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("wb_reg_write", 32'(wb_reg_write), 32'(m_we));
    chk("wb_dest", 32'(wb_dest), 32'(m_dest));
    chk("wb_data", wb_data, m_data);
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_dest = 0; a_data = 0;
    b_valid = 0; b_dest = 0; b_data = 0;
    issue_valid = 0; issue_dest = 0; q_src1 = 0; q_src2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    rst = 1;
  endtask

  typedef struct {
    logic av; logic [4:0] ad; logic [31:0] ada;
    logic bv; logic [4:0] bd; logic [31:0] bda;
    logic iv; logic [4:0] id; logic [4:0] s1;
    logic e_bready; logic e_iready; logic e_stall;
    logic e_we; logic [4:0] e_dest; logic [31:0] e_data; logic e_err;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ad, input logic [31:0] ada,
                              input logic bv, input logic [4:0] bd, input logic [31:0] bda,
                              input logic iv, input logic [4:0] id, input logic [4:0] s1,
                              input logic eb, input logic ei, input logic es,
                              input logic ew, input logic [4:0] ed, input logic [31:0] edata,
                              input logic ee);
    vec_t v;
    v.av = av; v.ad = ad; v.ada = ada; v.bv = bv; v.bd = bd; v.bda = bda;
    v.iv = iv; v.id = id; v.s1 = s1;
    v.e_bready = eb; v.e_iready = ei; v.e_stall = es;
    v.e_we = ew; v.e_dest = ed; v.e_data = edata; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    // A path, B path with scoreboard, A/FIFO-head collision; state carries row to row.
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,  1, 1, 0,  1, 5, 32'hDEADBEEF, 0);
    tbl[1]  = mk(1, 0, 32'h11111111, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 32'h11111111, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 5,  1, 1, 0,  0, 0, 32'h11111111, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0, 1, 7, 7,  1, 1, 0,  0, 0, 32'h11111111, 0);
    tbl[4]  = mk(0, 0, 0,            1, 7, 32'h12, 0, 0, 7,  1, 1, 1,  0, 0, 32'h11111111, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 7,  1, 1, 1,  1, 7, 32'h12, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 7,  1, 1, 1,  0, 7, 32'h12, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 7,  1, 1, 0,  0, 7, 32'h12, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0, 1, 9, 0,  1, 1, 0,  0, 7, 32'h12, 0);
    tbl[9]  = mk(0, 0, 0,            1, 9, 32'h99, 0, 0, 0,  1, 1, 0,  0, 7, 32'h12, 0);
    tbl[10] = mk(1, 3, 32'h33,       0, 0, 0, 0, 0, 9,  1, 1, 1,  1, 3, 32'h33, 0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0, 0, 0, 9,  1, 1, 1,  1, 9, 32'h99, 0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0, 0, 0, 9,  1, 1, 1,  0, 9, 32'h99, 0);

    idle_inputs();
    rst = 0;

    // Reset held 3 cycles with b_valid asserted; nothing may be enqueued.
    b_valid = 1; b_dest = 6; b_data = 32'hAAAA5555;
    repeat (3) step();
    q_src1 = 5;
    #1;
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1;
    idle_inputs();
    step();
    step();
    chk("rst_nothing_enqueued", 32'(wb_reg_write), 32'd0);

    for (int i = 0; i < 13; i++) begin
      a_valid = tbl[i].av; a_dest = tbl[i].ad; a_data = tbl[i].ada;
      b_valid = tbl[i].bv; b_dest = tbl[i].bd; b_data = tbl[i].bda;
      issue_valid = tbl[i].iv; issue_dest = tbl[i].id;
      q_src1 = tbl[i].s1; q_src2 = 0;
      #1;
      chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].e_bready));
      chk($sformatf("vec%0d_issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_iready));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      step();
      chk($sformatf("vec%0d_wb_we", i), 32'(wb_reg_write), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d_wb_dest", i), 32'(wb_dest), 32'(tbl[i].e_dest));
      chk($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].e_data);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].e_err));
    end

    // FIFO fills to DEPTH while A traffic starves the drain; no entry may be lost.
    do_reset();
    issue_valid = 1; issue_dest = 10; step();
    issue_dest = 11; step();
    issue_valid = 0; issue_dest = 0;
    a_valid = 1; a_dest = 1; a_data = 32'h0000A001;
    b_valid = 1; b_dest = 10; b_data = 32'hB0000010; step();
    b_dest = 11; b_data = 32'hB0000011; step();
    b_dest = 12; b_data = 32'hB0000012;
    #1;
    chk("full_b_ready", 32'(b_ready), 32'd0);
    step();
    a_valid = 0; b_valid = 0;
    step();
    chk("drain0_dest", 32'(wb_dest), 32'd10);
    chk("drain0_data", wb_data, 32'hB0000010);
    step();
    chk("drain1_dest", 32'(wb_dest), 32'd11);
    chk("drain1_data", wb_data, 32'hB0000011);
    step();
    chk("drain_done_we", 32'(wb_reg_write), 32'd0);
    chk("drain_err", 32'(err), 32'd0);

    // Re-issue of a pending destination.
    do_reset();
    issue_valid = 1; issue_dest = 4; step();
    #1;
    chk("reissue_ready", 32'(issue_ready), 32'd0);
    step();
    chk("reissue_err", 32'(err), 32'd1);
    issue_valid = 0;

    // Set and clear of dest 4 in the same cycle: set wins.
    do_reset();
    b_valid = 1; b_dest = 4; b_data = 32'h44; step();
    b_valid = 0; issue_valid = 1; issue_dest = 4; step();
    issue_valid = 0; step();
    q_src1 = 4;
    #1;
    chk("setclr_issue_ready", 32'(issue_ready), 32'd0);
    chk("setclr_stall", 32'(stall), 32'd1);
    chk("setclr_err", 32'(err), 32'd1);

    // Reset mid-operation with two buffered entries and two pending destinations.
    do_reset();
    issue_valid = 1; issue_dest = 7; step();
    issue_dest = 9; step();
    issue_valid = 0; issue_dest = 0;
    a_valid = 1; a_dest = 1; a_data = 32'h1;
    b_valid = 1; b_dest = 7; b_data = 32'h70; step();
    b_dest = 9; b_data = 32'h90; step();
    a_valid = 0; b_valid = 0;
    rst = 0; step(); rst = 1;
    q_src1 = 7; q_src2 = 9;
    #1;
    chk("midrst_b_ready", 32'(b_ready), 32'd1);
    chk("midrst_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_no_write%0d", i), 32'(wb_reg_write), 32'd0);
    end

    // Randomized traffic on a small register range to force collisions.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 149) != 0);
      a_valid     = ($urandom_range(0, 4) < 2);
      a_dest      = 5'($urandom_range(0, 7));
      a_data      = $urandom;
      b_valid     = ($urandom_range(0, 1) == 1);
      b_dest      = 5'($urandom_range(0, 7));
      b_data      = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_dest  = 5'($urandom_range(0, 7));
      q_src1      = 5'($urandom_range(0, 7));
      q_src2      = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
